// File: rtl/synchronous_fifo_pkg.sv
// Shared definitions for the synchronous FWFT FIFO: pointer width helper,
// the value shown on pop_data_o while the FIFO is empty, and a status struct.
package sync_fifo_pkg;

    // Widest data word the empty-value constant can cover.
    localparam int MAX_DATA_W = 1024;

    // Value driven on pop_data_o when no word is stored (all zeros).
    localparam logic [MAX_DATA_W-1:0] POP_DATA_RST = '0;

    // Occupancy flags decoded from the pointers.
    typedef struct packed {
        logic full;
        logic empty;
    } fifo_status_t;

    // Pointer width: index bits plus one wrap bit.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/synchronous_fifo_if.sv
// Push/pop bus of the synchronous FIFO.
//
// Handshake: push_i is a write request and is accepted on a rising edge when
// the FIFO is not full, or when it is full and pop_i is also high.
// pop_i is a read request and is accepted on a rising edge when the FIFO is
// not empty. pop_data_o always shows the head word (0 when empty), so the
// consumer sees the word it is about to pop before asserting pop_i.
// full_o / empty_o play the role of "ready" for push / pop respectively.
interface synchronous_fifo_if #(
    parameter int DATA_W = 8
);
    logic              push_i;
    logic [DATA_W-1:0] push_data_i;
    logic              pop_i;
    logic [DATA_W-1:0] pop_data_o;
    logic              full_o;
    logic              empty_o;

    // Producer/consumer side.
    modport master (
        output push_i,
        output push_data_i,
        output pop_i,
        input  pop_data_o,
        input  full_o,
        input  empty_o
    );

    // FIFO side.
    modport slave (
        input  push_i,
        input  push_data_i,
        input  pop_i,
        output pop_data_o,
        output full_o,
        output empty_o
    );
endinterface

// File: rtl/synchronous_fifo_mem.sv
// Storage array for the synchronous FIFO: DEPTH x DATA_W registers with one
// synchronous write port and one asynchronous read port. No reset.
module sync_fifo_mem #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Write the addressed entry on an accepted push.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/synchronous_fifo.sv
// Single-clock first-word-fall-through FIFO.
// Optional sticky overflow/underflow outputs exist only when the macro
// SYNC_FIFO_ERR_FLAGS_EN is defined.
module synchronous_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8
) (
    input  logic clk,
    input  logic reset,
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    output logic overflow_o,
    output logic underflow_o,
`endif
    synchronous_fifo_if.slave bus
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;

    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    fifo_status_t      w_status;
    logic              w_push_acc;
    logic              w_pop_acc;
    logic [DATA_W-1:0] w_rdata;

    // Flags are pure decodes of the registered pointers, so they track the
    // occupancy in the same cycle with no extra register stage.
    assign w_status.empty = (r_wr_ptr == r_rd_ptr);
    assign w_status.full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                            (r_wr_ptr[AW] != r_rd_ptr[AW]);

    // A push into a full FIFO is still taken when a pop frees the slot on
    // the same edge; a pop on an empty FIFO is never taken, even with a push.
    assign w_push_acc = bus.push_i && (!w_status.full || bus.pop_i);
    assign w_pop_acc  = bus.pop_i && !w_status.empty;

    // Advance write and read pointers on accepted requests.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    sync_fifo_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_mem (
        .i_clk   (clk),
        .i_we    (w_push_acc),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (bus.push_data_i),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (w_rdata)
    );

    assign bus.pop_data_o = w_status.empty ? POP_DATA_RST[DATA_W-1:0] : w_rdata;
    assign bus.full_o     = w_status.full;
    assign bus.empty_o    = w_status.empty;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    // Sticky error flags: record dropped pushes and ignored pops until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (bus.push_i && w_status.full && !bus.pop_i) begin
                r_overflow <= 1'b1;
            end
            if (bus.pop_i && w_status.empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign overflow_o  = r_overflow;
    assign underflow_o = r_underflow;
`endif

endmodule

// File: tb/tb_synchronous_fifo.sv
// Self-checking bench for synchronous_fifo: directed scenarios plus random
// push/pop traffic, compared every cycle against a queue-based model.
module tb_synchronous_fifo;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 8;

    logic clk;
    logic reset;

    synchronous_fifo_if #(.DATA_W(DATA_W)) bus ();

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic overflow_o;
    logic underflow_o;
`endif

    synchronous_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        .overflow_o  (overflow_o),
        .underflow_o (underflow_o),
`endif
        .bus         (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- counters / check helper ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DATA_W-1:0] exp_q[$];
    logic m_ov;
    logic m_un;

    // Occupancy-level model: decide acceptance from the queue size alone.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_q.delete();
            m_ov = 1'b0;
            m_un = 1'b0;
        end else begin
            automatic int  sz     = exp_q.size();
            automatic bit  is_full  = (sz == DEPTH);
            automatic bit  is_empty = (sz == 0);
            if (bus.push_i && is_full && !bus.pop_i) m_ov = 1'b1;
            if (bus.pop_i && is_empty) m_un = 1'b1;
            if (bus.pop_i && !is_empty) void'(exp_q.pop_front());
            if (bus.push_i && (!is_full || bus.pop_i)) exp_q.push_back(bus.push_data_i);
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (!reset) begin
            automatic logic [DATA_W-1:0] exp_head = (exp_q.size() > 0) ? exp_q[0] : '0;
            check("cyc_empty", {31'd0, bus.empty_o}, {31'd0, exp_q.size() == 0});
            check("cyc_full", {31'd0, bus.full_o}, {31'd0, exp_q.size() == DEPTH});
            check("cyc_data", {24'd0, bus.pop_data_o}, {24'd0, exp_head});
`ifdef SYNC_FIFO_ERR_FLAGS_EN
            check("cyc_overflow", {31'd0, overflow_o}, {31'd0, m_ov});
            check("cyc_underflow", {31'd0, underflow_o}, {31'd0, m_un});
`endif
        end
    end

    // ---------------- driver tasks ----------------
    // Apply one cycle of requests; inputs return to idle 1 time unit after the edge.
    task automatic step(input logic p, input logic [DATA_W-1:0] d, input logic q);
        bus.push_i      = p;
        bus.push_data_i = d;
        bus.pop_i       = q;
        @(posedge clk);
        #1;
        bus.push_i = 1'b0;
        bus.pop_i  = 1'b0;
    endtask

    task automatic push(input logic [DATA_W-1:0] d);
        step(1'b1, d, 1'b0);
    endtask

    task automatic pop();
        step(1'b0, '0, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    logic [DATA_W-1:0] seq3 [5];

    initial begin
        seq3[0] = 8'h09; seq3[1] = 8'h63; seq3[2] = 8'h0D; seq3[3] = 8'h8D; seq3[4] = 8'h65;

        bus.push_i      = 1'b0;
        bus.push_data_i = '0;
        bus.pop_i       = 1'b0;
        reset           = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset / idle values
        check("rst_empty", {31'd0, bus.empty_o}, 32'd1);
        check("rst_full", {31'd0, bus.full_o}, 32'd0);
        check("rst_data", {24'd0, bus.pop_data_o}, 32'd0);

        // Basic order and FWFT head
        push(8'h24); push(8'h81); push(8'h09); push(8'h63);
        check("head_24", {24'd0, bus.pop_data_o}, 32'h24);
        pop();
        check("head_81", {24'd0, bus.pop_data_o}, 32'h81);
        pop();
        check("head_09", {24'd0, bus.pop_data_o}, 32'h09);
        check("not_empty", {31'd0, bus.empty_o}, 32'd0);

        // Drain to empty
        push(8'h0D); push(8'h8D); push(8'h65);
        for (int i = 0; i < 5; i++) begin
            check("drain_head", {24'd0, bus.pop_data_o}, {24'd0, seq3[i]});
            pop();
        end
        check("drain_empty", {31'd0, bus.empty_o}, 32'd1);
        check("drain_data0", {24'd0, bus.pop_data_o}, 32'd0);

        // Fill, overflow drop, drain
        for (int i = 1; i <= DEPTH; i++) push(8'(i));
        check("fill_full", {31'd0, bus.full_o}, 32'd1);
        push(8'hFF);
        check("ovf_full", {31'd0, bus.full_o}, 32'd1);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        check("ovf_flag", {31'd0, overflow_o}, 32'd1);
`endif
        for (int i = 1; i <= DEPTH; i++) begin
            check("fill_order", {24'd0, bus.pop_data_o}, i);
            pop();
        end
        check("fill_empty", {31'd0, bus.empty_o}, 32'd1);

        // Simultaneous push/pop while full
        for (int i = 1; i <= DEPTH; i++) push(8'(i));
        step(1'b1, 8'hAA, 1'b1);
        check("full_pp_head", {24'd0, bus.pop_data_o}, 32'h02);
        check("full_pp_full", {31'd0, bus.full_o}, 32'd1);
        for (int i = 2; i <= DEPTH; i++) begin
            check("full_pp_order", {24'd0, bus.pop_data_o}, i);
            pop();
        end
        check("full_pp_last", {24'd0, bus.pop_data_o}, 32'hAA);
        pop();

        // Simultaneous push/pop while empty
        step(1'b1, 8'h55, 1'b1);
        check("empty_pp_empty", {31'd0, bus.empty_o}, 32'd0);
        check("empty_pp_head", {24'd0, bus.pop_data_o}, 32'h55);
        pop();

        // Pop on empty leaves pointers unchanged
        pop();
        check("pop_empty", {31'd0, bus.empty_o}, 32'd1);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        check("udf_flag", {31'd0, underflow_o}, 32'd1);
`endif
        push(8'h3C);
        check("after_udf_head", {24'd0, bus.pop_data_o}, 32'h3C);
        pop();

        // Random traffic with wrap-around
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end

        // Reset mid-stream with three stored words
        while (!bus.empty_o) pop();
        push(8'hA1); push(8'hA2); push(8'hA3);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_empty", {31'd0, bus.empty_o}, 32'd1);
        check("mid_rst_full", {31'd0, bus.full_o}, 32'd0);
        check("mid_rst_data", {24'd0, bus.pop_data_o}, 32'd0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        check("mid_rst_ovf", {31'd0, overflow_o}, 32'd0);
        check("mid_rst_udf", {31'd0, underflow_o}, 32'd0);
`endif
        @(posedge clk);
        #1 reset = 1'b0;
        push(8'h77);
        check("post_rst_head", {24'd0, bus.pop_data_o}, 32'h77);
        repeat (2) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/synchronous_fifo.md
Name: synchronous_fifo

Overview:
Single-clock first-word-fall-through (FWFT) FIFO buffering DATA_W-bit words, DEPTH entries deep. It sits between a producer and a consumer in the same clock domain. Interface is a push/pop handshake with full/empty status. The head word is always visible on pop_data_o without a read-latency cycle.

Parameters:
DEPTH, 8, number of entries; power of two, minimum 2.
DATA_W, 8, width in bits of each data word.

Ports:
clk  input  1  sole clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
push_i  input  1  write request; sampled on the rising edge of clk.
push_data_i  input  DATA_W  write data; captured when a push is accepted.
pop_i  input  1  read request; sampled on the rising edge of clk.
pop_data_o  output  DATA_W  current head word (FWFT); 0 when empty.
full_o  output  1  FIFO holds DEPTH words.
empty_o  output  1  FIFO holds 0 words.

Interface decision: one clock (clk); reset is asynchronous and active-high (reset).

Behaviour:
- Reset (async assert, state cleared immediately): write pointer=0, read pointer=0, empty_o=1, full_o=0, pop_data_o=0. Storage array is not reset. Reset asserted mid-operation discards all contents.
- Pointers: width $clog2(DEPTH)+1; MSB is the wrap bit.
  - empty when the pointers are fully equal.
  - full when the index bits are equal and the wrap bits differ.
  - Indices wrap DEPTH-1 -> 0.
- Accepted push = push_i && (!full_o || pop_i). On the clock edge: mem[wr_idx] <= push_data_i; wr_ptr increments.
- Accepted pop = pop_i && !empty_o. On the clock edge: rd_ptr increments.
- pop_data_o is combinational: mem[rd_idx] when !empty_o, else 0. It shows the oldest word before pop_i is asserted, and the next word in the cycle after the pop edge.
- Latency: a word pushed at edge N appears on pop_data_o after edge N when the FIFO was empty. empty_o deasserts after that same edge.
- full_o and empty_o are combinational decodes of the registered pointers. No registered-flag lag.
- Push while full with pop_i=0: dropped; no state change.
- Pop while empty: ignored; pointers unchanged.
- Push and pop in the same cycle:
  - Not empty (including full): both execute; occupancy unchanged; full_o stays as before.
  - Empty: push executes, pop ignored; occupancy becomes 1.
- Data order is strictly FIFO across wrap-around.

Optional Feature:
Macro SYNC_FIFO_ERR_FLAGS_EN.
- When defined, two extra output ports are added: overflow_o and underflow_o (1 bit each, sticky, cleared only by reset).
  - overflow_o sets on the edge where push_i=1, full_o=1 and pop_i=0.
  - underflow_o sets on the edge where pop_i=1 and empty_o=1.
- When undefined, the ports and logic do not exist, and dropped or ignored requests are silent.

Decomposition:
- Package sync_fifo_pkg: function for pointer width ($clog2(DEPTH)+1) and a reset-value constant for pop_data_o (all zeros).
- Sub-module sync_fifo_mem: DEPTH x DATA_W register array with a synchronous write port and an asynchronous read port, no reset.
- Top level holds the pointers, flag decode, handshake qualification and the optional error flags.

Test Plan:
- Reset, then idle -> empty_o=1, full_o=0, pop_data_o=0. Assert reset mid-stream with 3 words stored -> flags return to the reset values immediately, without waiting for a clock edge.
- Push 0x24, 0x81, 0x09, 0x63, then pop twice -> pop_data_o reads 0x24 before the first pop and 0x81 before the second. After the pops, head=0x09 and empty_o=0.
- Push 0x0D, 0x8D, 0x65, then pop until empty -> sequence 0x09, 0x63, 0x0D, 0x8D, 0x65. empty_o=1 after the fifth pop, and pop_data_o=0.
- Push 8 words 0x01..0x08 -> full_o=1 after the 8th edge. A 9th push of 0xFF is dropped (overflow_o=1 if the macro is enabled). Popping 8 words returns 0x01..0x08.
- While full, push 0xAA and pop in the same cycle -> head advances to 0x02, full_o stays 1, and 0xAA later emerges last. While empty, push 0x55 with pop_i=1 -> 0x55 is stored and empty_o=0.
- Wrap-around: 20 push/pop cycles with a random mix of 0–7 entries and a scoreboard -> exact order match. Pop on empty causes no pointer change (underflow_o=1 if the macro is enabled).
